// File: rtl/e_bus_arbiter.sv
// E-bus arbiter: shares the 6800-style E bus between the CPU (VPA cycles) and a local requester.
// Define E_BUS_STARVE_GUARD_EN to let the local requester win after STARVE_MAX lost contested slots.
module e_bus_arbiter #(
    parameter int STARVE_MAX = 2
) (
    input  logic       C7M,
    input  logic       RESET_n,
    input  logic [3:0] E_PHASE,
    input  logic       VPA_n,
    input  logic       CPUSPACE,
    input  logic       AS_CPU_n,
    input  logic       LREQ,
    output logic       CPU_DTACK_n,
    output logic       LGNT,
    output logic       LDONE,
    output logic       BUS_VMA_n,
    output logic       BUS_OWNER
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_TERM   = 2'd2;

    logic [1:0] state;
    logic       creq;
    logic       phase_ok;
    logic       decide;
    logic       local_win;
    logic       cpu_abort;

    assign creq      = !VPA_n && !CPUSPACE && !AS_CPU_n;
    assign phase_ok  = (E_PHASE <= 4'd9);
    assign decide    = (state == S_IDLE) && (E_PHASE == 4'd3);
    assign cpu_abort = VPA_n || AS_CPU_n;

`ifdef E_BUS_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign local_win = LREQ && (!creq || (starve_cnt == 3'(STARVE_MAX)));

    // Counts only contested slots the local side lost; any local grant clears it.
    always_ff @(negedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            starve_cnt <= 3'd0;
        end else if (decide) begin
            if (local_win)
                starve_cnt <= 3'd0;
            else if (creq && LREQ && starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign local_win = LREQ && !creq;
`endif

    always_ff @(negedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= S_IDLE;
            CPU_DTACK_n <= 1'b1;
            BUS_VMA_n   <= 1'b1;
            LGNT        <= 1'b0;
            LDONE       <= 1'b0;
            BUS_OWNER   <= 1'b0;
        end else if (phase_ok) begin
            LDONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (decide && (creq || LREQ)) begin
                        BUS_VMA_n <= 1'b0;
                        BUS_OWNER <= local_win;
                        LGNT      <= local_win;
                        state     <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // A CPU that drops VPA/AS mid-cycle forfeits the slot with no DTACK.
                    if (!BUS_OWNER && cpu_abort) begin
                        BUS_VMA_n <= 1'b1;
                        state     <= S_IDLE;
                    end else if (E_PHASE == 4'd9) begin
                        BUS_VMA_n <= 1'b1;
                        LGNT      <= 1'b0;
                        state     <= S_TERM;
                        if (BUS_OWNER)
                            LDONE <= 1'b1;
                        else
                            CPU_DTACK_n <= 1'b0;
                    end
                end
                S_TERM: begin
                    if (BUS_OWNER) begin
                        state <= S_IDLE;
                    end else if (AS_CPU_n) begin
                        CPU_DTACK_n <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_bus_arbiter.sv
// Self-checking bench for e_bus_arbiter; grant owners are scored against an expected-owner queue.
module tb_e_bus_arbiter;

    logic       C7M = 1'b1;
    logic       RESET_n;
    logic [3:0] E_PHASE;
    logic       VPA_n, CPUSPACE, AS_CPU_n, LREQ;
    logic       CPU_DTACK_n, LGNT, LDONE, BUS_VMA_n, BUS_OWNER;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_ph;
    bit         exp_q[$];

    e_bus_arbiter dut (
        .C7M(C7M), .RESET_n(RESET_n), .E_PHASE(E_PHASE), .VPA_n(VPA_n),
        .CPUSPACE(CPUSPACE), .AS_CPU_n(AS_CPU_n), .LREQ(LREQ),
        .CPU_DTACK_n(CPU_DTACK_n), .LGNT(LGNT), .LDONE(LDONE),
        .BUS_VMA_n(BUS_VMA_n), .BUS_OWNER(BUS_OWNER)
    );

    always #10 C7M = ~C7M;

    // One falling edge; afterwards last_ph is the phase that edge sampled.
    task automatic cyc();
        @(negedge C7M);
        #1;
        last_ph = E_PHASE;
        if (E_PHASE < 4'd9) E_PHASE = E_PHASE + 4'd1;
        else if (E_PHASE == 4'd9) E_PHASE = 4'd0;
    endtask

    task automatic run_to_phase(input logic [3:0] k);
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (last_ph == k) return;
        end
        errors++; checks++;
        $display("FAIL run_to_phase: phase %0d not reached, last=%0d", k, last_ph);
    endtask

    task automatic test_reset();
        RESET_n = 1'b0; LREQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({CPU_DTACK_n, BUS_VMA_n, LGNT, LDONE, BUS_OWNER} !== 5'b11000) begin
                errors++;
                $display("FAIL rst_outputs ph%0d got=%b exp=11000", last_ph,
                         {CPU_DTACK_n, BUS_VMA_n, LGNT, LDONE, BUS_OWNER});
            end
        end
        RESET_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (!BUS_VMA_n) break;
        end
        checks++;
        if (BUS_VMA_n !== 1'b0 || last_ph !== 4'd3) begin
            errors++;
            $display("FAIL rst_first_grant vma=%b ph=%0d exp vma=0 ph=3", BUS_VMA_n, last_ph);
        end
        checks++;
        if (LGNT !== 1'b1) begin errors++; $display("FAIL rst_first_lgnt got=%b exp=1", LGNT); end
        LREQ = 1'b0;
        run_to_phase(4'd2);
    endtask

    task automatic test_cpu();
        run_to_phase(4'd0);
        VPA_n = 1'b0; AS_CPU_n = 1'b0;
        exp_q.push_back(1'b0);
        cyc(); cyc();
        checks++;
        if (BUS_VMA_n !== 1'b1) begin errors++; $display("FAIL cpu_vma_early got=%b exp=1", BUS_VMA_n); end
        cyc();
        checks++;
        if (BUS_VMA_n !== 1'b0 || exp_q.size() == 0) begin
            errors++; $display("FAIL cpu_grant vma=%b exp=0", BUS_VMA_n);
        end else begin
            bit e = exp_q.pop_front();
            checks++;
            if (BUS_OWNER !== e || LGNT !== 1'b0) begin
                errors++; $display("FAIL cpu_owner owner=%b lgnt=%b exp owner=%b lgnt=0", BUS_OWNER, LGNT, e);
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (CPU_DTACK_n !== 1'b1 || BUS_VMA_n !== 1'b0) begin
                errors++; $display("FAIL cpu_active ph%0d dtack=%b vma=%b exp 1,0", last_ph, CPU_DTACK_n, BUS_VMA_n);
            end
        end
        cyc();
        checks++;
        if (CPU_DTACK_n !== 1'b0 || BUS_VMA_n !== 1'b1) begin
            errors++; $display("FAIL cpu_ph9 dtack=%b vma=%b exp 0,1", CPU_DTACK_n, BUS_VMA_n);
        end
        cyc(); cyc();
        checks++;
        if (CPU_DTACK_n !== 1'b0) begin errors++; $display("FAIL cpu_dtack_hold got=%b exp=0", CPU_DTACK_n); end
        AS_CPU_n = 1'b1; VPA_n = 1'b1;
        cyc();
        checks++;
        if (CPU_DTACK_n !== 1'b1) begin errors++; $display("FAIL cpu_dtack_release got=%b exp=1", CPU_DTACK_n); end
    endtask

    task automatic test_local_back_to_back();
        run_to_phase(4'd2);
        LREQ = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (LGNT !== (last_ph >= 4'd3 && last_ph <= 4'd8) || LDONE !== (last_ph == 4'd9) || BUS_OWNER !== 1'b1) begin
                errors++;
                $display("FAIL local_seq i=%0d ph%0d lgnt=%b ldone=%b owner=%b exp %b,%b,1", i, last_ph,
                         LGNT, LDONE, BUS_OWNER, (last_ph >= 4'd3 && last_ph <= 4'd8), (last_ph == 4'd9));
            end
            // Drop the request inside the second access; it must still complete.
            if (i == 11) LREQ = 1'b0;
        end
        cyc();
        checks++;
        if (BUS_VMA_n !== 1'b1 || LGNT !== 1'b0) begin
            errors++; $display("FAIL local_no_regrant vma=%b lgnt=%b exp 1,0", BUS_VMA_n, LGNT);
        end
    endtask

    task automatic test_abort();
        run_to_phase(4'd2);
        VPA_n = 1'b0; AS_CPU_n = 1'b0;
        cyc();
        checks++;
        if (BUS_VMA_n !== 1'b0 || BUS_OWNER !== 1'b0) begin
            errors++; $display("FAIL abort_grant vma=%b owner=%b exp 0,0", BUS_VMA_n, BUS_OWNER);
        end
        cyc(); cyc();
        VPA_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++;
            if (BUS_VMA_n !== 1'b1 || CPU_DTACK_n !== 1'b1) begin
                errors++; $display("FAIL abort ph%0d vma=%b dtack=%b exp 1,1", last_ph, BUS_VMA_n, CPU_DTACK_n);
            end
        end
        AS_CPU_n = 1'b1;
    endtask

    task automatic test_cpuspace();
        run_to_phase(4'd1);
        CPUSPACE = 1'b1; VPA_n = 1'b0; AS_CPU_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (BUS_VMA_n !== 1'b1) begin errors++; $display("FAIL cpuspace ph%0d vma=%b exp=1", last_ph, BUS_VMA_n); end
        end
        CPUSPACE = 1'b0; VPA_n = 1'b1; AS_CPU_n = 1'b1;
    endtask

    task automatic test_starve();
        logic prev_vma;
        run_to_phase(4'd2);
        for (int s = 0; s < 6; s++) begin
`ifdef E_BUS_STARVE_GUARD_EN
            exp_q.push_back(s % 3 == 2);
`else
            exp_q.push_back(1'b0);
`endif
        end
        LREQ = 1'b1; VPA_n = 1'b0; AS_CPU_n = 1'b0;
        prev_vma = BUS_VMA_n;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (prev_vma && !BUS_VMA_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL starve_extra_grant ph%0d exp none", last_ph);
                end else begin
                    bit e = exp_q.pop_front();
                    if (BUS_OWNER !== e || LGNT !== e) begin
                        errors++; $display("FAIL starve_owner i=%0d owner=%b lgnt=%b exp=%b", i, BUS_OWNER, LGNT, e);
                    end
                end
            end
            if (BUS_OWNER && !BUS_VMA_n) begin
                checks++;
                if (CPU_DTACK_n !== 1'b1) begin errors++; $display("FAIL starve_cpu_wait dtack=%b exp=1", CPU_DTACK_n); end
            end
            prev_vma = BUS_VMA_n;
            if (!CPU_DTACK_n) begin AS_CPU_n = 1'b1; VPA_n = 1'b1; end
            else if (AS_CPU_n) begin AS_CPU_n = 1'b0; VPA_n = 1'b0; end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL starve_missing_grants left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        LREQ = 1'b0; AS_CPU_n = 1'b1; VPA_n = 1'b1;
        run_to_phase(4'd2);
    endtask

    task automatic test_phase_hold();
        run_to_phase(4'd2);
        LREQ = 1'b1;
        cyc(); cyc(); cyc();
        E_PHASE = 4'd12;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (LGNT !== 1'b1 || BUS_VMA_n !== 1'b0 || LDONE !== 1'b0) begin
                errors++; $display("FAIL hold ph%0d lgnt=%b vma=%b ldone=%b exp 1,0,0", last_ph, LGNT, BUS_VMA_n, LDONE);
            end
        end
        E_PHASE = 4'd6;
        LREQ = 1'b0;
        run_to_phase(4'd9);
        checks++;
        if (LDONE !== 1'b1 || LGNT !== 1'b0) begin
            errors++; $display("FAIL hold_done ldone=%b lgnt=%b exp 1,0", LDONE, LGNT);
        end
    endtask

    task automatic test_reset_mid();
        run_to_phase(4'd2);
        LREQ = 1'b1;
        run_to_phase(4'd7);
        RESET_n = 1'b0;
        #1;
        checks++;
        if ({CPU_DTACK_n, BUS_VMA_n, LGNT, LDONE, BUS_OWNER} !== 5'b11000) begin
            errors++; $display("FAIL midrst_outputs got=%b exp=11000", {CPU_DTACK_n, BUS_VMA_n, LGNT, LDONE, BUS_OWNER});
        end
        cyc();
        RESET_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (LDONE !== 1'b0 || LGNT !== 1'b0) begin
                errors++; $display("FAIL midrst_idle ph%0d ldone=%b lgnt=%b exp 0,0", last_ph, LDONE, LGNT);
            end
        end
        cyc();
        checks++;
        if (last_ph !== 4'd3 || LGNT !== 1'b1) begin
            errors++; $display("FAIL midrst_regrant ph%0d lgnt=%b exp ph3 lgnt=1", last_ph, LGNT);
        end
        LREQ = 1'b0;
        run_to_phase(4'd2);
    endtask

    initial begin
        E_PHASE = 4'd0; RESET_n = 1'b0; VPA_n = 1'b1; CPUSPACE = 1'b0;
        AS_CPU_n = 1'b1; LREQ = 1'b0;
        test_reset();
        test_cpu();
        test_local_back_to_back();
        test_abort();
        test_cpuspace();
        test_starve();
        test_phase_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
